// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO.
// A byte written into an empty FIFO while idle starts its start bit on the very next edge.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [11:0]   BIT_RELOAD = 12'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [1:0]    state;
  logic [11:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          push;
  logic          pop;
  logic          bit_done;

  // wr_ready looks only at the registered count, so a same-edge pop never frees a slot early
  assign wr_ready = fifo_count < DEPTH_C;
  assign push     = wr_valid && wr_ready;
  assign bit_done = bit_cnt == '0;
  assign pop      = (fifo_count != '0) && ((state == IDLE) || ((state == STOP) && bit_done));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The bit counter only decrements while non-zero; zero marks the last cycle of each bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= START;
            txd       <= 1'b0;
            bit_cnt   <= BIT_RELOAD;
            shift_reg <= mem[rd_ptr];
          end
        end
        START: begin
          if (bit_done) begin
            state     <= DATA;
            txd       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
            bit_cnt   <= BIT_RELOAD;
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (pop) begin
              state     <= START;
              txd       <= 1'b0;
              bit_cnt   <= BIT_RELOAD;
              shift_reg <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: instance a at default timing, instance b at 4 clocks/bit.
// Each instance has a serial monitor that decodes bytes from txd into a queue.
module tb_uart_tx_fifo;

  localparam int CPB_A = 217;
  localparam int CPB_B = 4;

  typedef struct {
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       exp_ready;
    logic [2:0] exp_count;
    logic       exp_busy;
    logic       exp_txd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n_a, wr_valid_a, wr_ready_a, txd_a, busy_a;
  logic [7:0] wr_data_a;
  logic [2:0] fifo_count_a;
  logic       rst_n_b, wr_valid_b, wr_ready_b, txd_b, busy_b;
  logic [7:0] wr_data_b;
  logic [2:0] fifo_count_b;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  uart_tx_fifo dut_a (
    .clk(clk), .rst_n(rst_n_a), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
    .wr_ready(wr_ready_a), .txd(txd_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
    .wr_ready(wr_ready_b), .txd(txd_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  initial begin : mon_a
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd_a === 1'b0) begin
        repeat (CPB_A / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB_A) @(negedge clk);
          b[i] = txd_a;
        end
        repeat (CPB_A) @(negedge clk);
        rx_a.push_back(b);
      end
    end
  end

  initial begin : mon_b
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txd_b === 1'b0) begin
        repeat (CPB_B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB_B) @(negedge clk);
          b[i] = txd_b;
        end
        repeat (CPB_B) @(negedge clk);
        rx_b.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one DUT's inputs on the falling edge, then land just after the next rising edge
  task automatic applyStimulus(input bit sel_b, input logic rst, input logic v, input logic [7:0] d);
    @(negedge clk);
    if (sel_b) begin
      rst_n_b = rst; wr_valid_b = v; wr_data_b = d;
    end else begin
      rst_n_a = rst; wr_valid_a = v; wr_data_a = d;
    end
    @(posedge clk);
    #1;
  endtask

  // Compares txd_a cycle by cycle against back-to-back 8N1 frames, then checks the return to idle
  task automatic checkStream(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input int nframes, input int first_c);
    int bad_txd = 0;
    int bad_busy = 0;
    int fl = 10 * CPB_A;
    for (int c = first_c; c < nframes * fl; c++) begin
      int f;
      int bi;
      logic [7:0] d;
      logic e;
      @(posedge clk);
      #1;
      f  = c / fl;
      bi = (c % fl) / CPB_A;
      d  = (f == 0) ? d0 : ((f == 1) ? d1 : d2);
      if (bi == 0)      e = 1'b0;
      else if (bi == 9) e = 1'b1;
      else              e = d[bi-1];
      if (txd_a !== e)     bad_txd++;
      if (busy_a !== 1'b1) bad_busy++;
    end
    checkOutput("stream txd mismatching cycles", bad_txd, 0);
    checkOutput("stream busy low cycles", bad_busy, 0);
    @(posedge clk);
    #1;
    checkOutput("busy after last stop", busy_a, 1'b0);
    checkOutput("txd idle after last stop", txd_a, 1'b1);
  endtask

  task automatic waitRx(input bit sel_b, input int n, input int budget);
    int k = 0;
    while (((sel_b ? rx_b.size() : rx_a.size()) < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    checkOutput("monitor byte count", sel_b ? rx_b.size() : rx_a.size(), n);
  endtask

  initial begin
    int waited;
    int bad;
    bit accepted;
    logic [7:0] exp_b6 [6];
    logic [7:0] exp_b4 [4];

    rst_n_a = 1'b0; wr_valid_a = 1'b0; wr_data_a = 8'h00;
    rst_n_b = 1'b0; wr_valid_b = 1'b0; wr_data_b = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h7E, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 1'b1, 3'd3, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 8'hE7, 1'b0, 3'd4, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h5A, 1'b0, 3'd4, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1};
    exp_b6 = '{8'hA5, 8'h3C, 8'h7E, 8'h81, 8'hE7, 8'h5A};
    exp_b4 = '{8'h12, 8'h34, 8'h56, 8'h78};

    // Reset, fill-to-full and overflow rejection on instance b
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vecs[i].rst_n, vecs[i].wr_valid, vecs[i].wr_data);
      checkOutput($sformatf("vec%0d {ready,count,busy,txd}", i),
                  {26'd0, wr_ready_b, fifo_count_b, busy_b, txd_b},
                  {26'd0, vecs[i].exp_ready, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_txd});
    end

    // Sixth byte waits until the second frame pops
    waited = 0;
    accepted = 1'b0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      wr_valid_b = 1'b1;
      wr_data_b  = 8'h5A;
      if (wr_ready_b) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    wr_valid_b = 1'b0;
    checkOutput("sixth byte accepted", accepted, 1'b1);
    checkOutput("cycles with wr_ready low", waited, 35);
    checkOutput("count after sixth accept", fifo_count_b, 3'd4);
    waitRx(1'b1, 6, 1000);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("full-fifo byte %0d", i), (rx_b.size() > i) ? rx_b[i] : 8'hxx, exp_b6[i]);
    end

    // Instance a reset state, then single 'O'
    checkOutput("a reset {ready,count,busy,txd}", {wr_ready_a, fifo_count_a, busy_a, txd_a}, {1'b1, 3'd0, 1'b0, 1'b1});
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h4F);
    wr_valid_a = 1'b0;
    checkOutput("O queued count", fifo_count_a, 3'd1);
    checkOutput("O queued busy", busy_a, 1'b1);
    checkStream(8'h4F, 8'h00, 8'h00, 1, 0);
    checkOutput("decoded O", (rx_a.size() == 1) ? rx_a[0] : 8'hxx, 8'h4F);
    rx_a.delete();

    // "OK\n" on consecutive edges
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h4F);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h4B);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h0A);
    wr_valid_a = 1'b0;
    checkOutput("OK count after writes", fifo_count_a, 3'd2);
    checkOutput("OK start bit", txd_a, 1'b0);
    checkStream(8'h4F, 8'h4B, 8'h0A, 3, 2);
    waitRx(1'b0, 3, 10);
    checkOutput("OK bytes", {rx_a[0], rx_a[1], rx_a[2]}, {8'h4F, 8'h4B, 8'h0A});
    rx_a.delete();

    // Push and pop on the same edge with two bytes queued (instance b)
    waited = 0;
    while (busy_b && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("b idle before same-edge test", busy_b, 1'b0);
    rx_b.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h12);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h34);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h56);
    for (int i = 0; i < 38; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("count before same-edge push/pop", fifo_count_b, 3'd2);
    checkOutput("stop bit before same-edge push/pop", txd_b, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h78);
    checkOutput("count after same-edge push/pop", fifo_count_b, 3'd2);
    checkOutput("start bit after same-edge pop", txd_b, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitRx(1'b1, 4, 1000);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("order byte %0d", i), (rx_b.size() > i) ? rx_b[i] : 8'hxx, exp_b4[i]);
    end

    // Reset in the middle of a 0x55 frame with two bytes queued (instance a)
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hCC);
    wr_valid_a = 1'b0;
    checkOutput("pre-abort count", fifo_count_a, 3'd2);
    repeat (998) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    checkOutput("abort {ready,count,busy,txd}", {wr_ready_a, fifo_count_a, busy_a, txd_a}, {1'b1, 3'd0, 1'b0, 1'b1});
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    checkOutput("write ignored in reset", fifo_count_a, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    bad = 0;
    for (int c = 0; c < 20 * CPB_A; c++) begin
      @(posedge clk);
      #1;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    checkOutput("no frame after reset release", bad, 0);
    rx_a.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning clocks per UART bit (25 MHz / 115200 baud); legal range 2..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port wr_data  input  8  byte to transmit.
REQ-006 SHALL have port wr_valid  input  1  write request; byte accepted on an edge where wr_valid && wr_ready.
REQ-007 SHALL have port wr_ready  output  1  high when the FIFO is not full.
REQ-008 SHALL have port txd  output  1  serial line, idle high; drives uo_out[0].
REQ-009 SHALL have port busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in flight.

Function
REQ-011 SHALL send 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; IDLE->START when the FIFO is non-empty; START->DATA and DATA(bit 7)->STOP after CLKS_PER_BIT cycles; STOP->START if the FIFO is non-empty, else STOP->IDLE.
REQ-013 SHALL register txd (no combinational path from any input to txd).
REQ-014 SHALL, for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, pop it and register txd=0 at edge N+1.
REQ-015 SHALL send back-to-back frames with no idle gap: the next start bit begins the cycle after the last stop-bit cycle.
REQ-016 SHALL pop the FIFO exactly on the IDLE->START or STOP->START transition edge, latching the byte into a shift register.
REQ-017 SHALL drive wr_ready combinationally from fifo_count only: wr_ready = (fifo_count < FIFO_DEPTH); a pop on the same edge does not raise wr_ready early.
REQ-018 SHALL ignore wr_valid while wr_ready=0 (no overwrite, no count change).
REQ-019 SHALL, on a simultaneous push and pop on one edge, leave fifo_count unchanged and keep FIFO order.
REQ-020 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH and use the extra count bit to distinguish full from empty.
REQ-021 SHALL count bits with a down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary; the counter never underflows.
REQ-022 SHALL deassert busy on the edge entering IDLE with the FIFO empty.

Reset
REQ-023 SHALL, while rst_n=0 at a rising edge: txd=1, busy=0, fifo_count=0, wr_ready=1, FSM=IDLE, pointers and bit counters 0.
REQ-024 SHALL abort any frame in progress when reset asserts mid-frame; txd=1 from that edge onward, and queued bytes are discarded.
REQ-025 SHALL ignore wr_valid during reset and start no frame until the first edge with rst_n=1 and a non-empty FIFO.

Verification
REQ-026 SHALL cover single byte 0x4F at defaults -> txd low 217 cycles, then bits 1,1,1,1,0,0,1,0 at 217 cycles each, then high 217 cycles; a 217-clock monitor decodes 'O'.
REQ-027 SHALL cover writing "OK\n" (0x4F,0x4B,0x0A) on three consecutive edges -> three contiguous frames, 6510 cycles total, no idle gap, busy low 1 cycle after the last stop bit.
REQ-028 SHALL cover CLKS_PER_BIT=4, FIFO_DEPTH=4, writing 6 bytes on consecutive edges -> 5 accepted (1 in flight + 4 queued), wr_ready=0 for the 6th, the 6th accepted once the second frame pops, all bytes emitted in order.
REQ-029 SHALL cover reset asserted at cycle 1000 of a 0x55 frame with 2 bytes queued -> txd=1, fifo_count=0, busy=0 the next edge; no further start bit after release.
REQ-030 SHALL cover push and pop on the same edge with fifo_count=2 -> fifo_count stays 2 and the output byte order is preserved.
